// File: rtl/uart_rx_buf_if.sv
// ---------------------------------------------------------------------------
// uart_rx_buf_if
//   Stream handshake carrying received UART words out of the receive buffer.
//
//   Signals:
//     m_axis_tdata   head-of-buffer word (DATA_WIDTH bits)
//     m_axis_tvalid  buffer holds at least one word
//     m_axis_tready  consumer accepts the head word this cycle
//
//   Modports:
//     master  - the receiver side (drives data/valid, samples ready)
//     slave   - the consumer side (samples data/valid, drives ready)
// ---------------------------------------------------------------------------
interface uart_rx_buf_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/uart_rx_buf.sv
// ---------------------------------------------------------------------------
// uart_rx_buf
//   UART receiver with optional parity check and a small receive FIFO.
//   The serial line is synchronized, framed by a start/data/parity/stop
//   state machine sampling mid-bit, and good words are pushed into a FIFO
//   that is drained through a valid/ready stream interface.
//
//   Ports:
//     clk_i             clock, all logic on the rising edge
//     rst_ni            asynchronous active-low reset
//     RX_i              serial line (idle high), asynchronous to clk_i
//     prescale          clock cycles per bit period (values < 4 act as 4)
//     m_axis            stream master: tdata / tvalid out, tready in
//     rx_busy           a frame is being received (FSM not idle)
//     rx_frame_error    1-cycle pulse: stop bit sampled low, word dropped
//     rx_parity_error   1-cycle pulse: parity mismatch, word dropped
//     rx_overrun_error  1-cycle pulse: good word dropped, buffer full
//     fifo_count        number of words currently buffered
// ---------------------------------------------------------------------------
module uart_rx_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           RX_i,
    input  logic [15:0]                    prescale,
    uart_rx_buf_if.master                  m_axis,
    output logic                           rx_busy,
    output logic                           rx_frame_error,
    output logic                           rx_parity_error,
    output logic                           rx_overrun_error,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int         CW       = $clog2(FIFO_DEPTH + 1);
    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer and falling-edge detector
    // ------------------------------------------------------------------
    logic       r_rx_meta;
    logic       r_rx_sync;
    logic       r_rx_prev;
    // Fills with ones after reset; bit 2 set means both r_rx_prev and
    // r_rx_sync hold real line samples rather than reset values, so a line
    // held low through reset is never mistaken for a start edge.
    logic [2:0] r_sync_vld;
    logic       w_fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_sync_vld <= 3'b000;
        end else begin
            r_rx_meta  <= RX_i;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_sync_vld <= {r_sync_vld[1:0], 1'b1};
        end
    end

    assign w_fall = r_sync_vld[2] & r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_cnt;
    logic [15:0]           w_cnt_next;
    logic [15:0]           r_prescale;
    logic [15:0]           w_prescale_next;
    logic [15:0]           w_presc_in;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            w_bit_cnt_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  r_par_bit;
    logic                  w_par_bit_next;
    logic                  w_resolve;

    assign w_presc_in = (prescale < 16'd4) ? 16'd4 : prescale;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_prescale <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_prescale <= w_prescale_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_par_bit  <= w_par_bit_next;
        end
    end

    // r_cnt counts down to the next sample point; a sample is taken in the
    // cycle where it reads zero.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_prescale_next = r_prescale;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_par_bit_next  = r_par_bit;
        w_resolve       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_prescale_next = w_presc_in;
                    w_cnt_next      = (w_presc_in >> 1) - 16'd1;
                    w_state_next    = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == 16'd0) begin
                    if (!r_rx_sync) begin
                        w_cnt_next     = r_prescale - 16'd1;
                        w_bit_cnt_next = '0;
                        w_state_next   = ST_DATA;
                    end else begin
                        // Line back high at mid start bit: a glitch.
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (r_cnt == 16'd0) begin
                    w_shift_next = {r_rx_sync, r_shift[DATA_WIDTH-1:1]};
                    w_cnt_next   = r_prescale - 16'd1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            ST_PARITY: begin
                if (r_cnt == 16'd0) begin
                    w_par_bit_next = r_rx_sync;
                    w_cnt_next     = r_prescale - 16'd1;
                    w_state_next   = ST_STOP;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (r_cnt == 16'd0) begin
                    w_resolve    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_busy = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Frame resolution: stop bit beats parity beats overrun
    // ------------------------------------------------------------------
    logic w_par_calc;
    logic w_par_ok;
    logic w_stop_ok;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic r_frame_err;
    logic r_par_err;
    logic r_ovr_err;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         w_rd_ptr_inc;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_tdata;

    assign w_par_calc = ^{r_shift, r_par_bit};
    assign w_par_ok   = (PARITY == 0) ? 1'b1 :
                        (PARITY == 1) ? ~w_par_calc : w_par_calc;
    assign w_stop_ok  = r_rx_sync;
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_pop      = (r_count != '0) & m_axis.m_axis_tready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_push     = w_resolve & w_stop_ok & w_par_ok & (~w_full | w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_frame_err <= w_resolve & ~w_stop_ok;
            r_par_err   <= w_resolve & w_stop_ok & ~w_par_ok;
            r_ovr_err   <= w_resolve & w_stop_ok & w_par_ok & w_full & ~w_pop;
        end
    end

    assign rx_frame_error   = r_frame_err;
    assign rx_parity_error  = r_par_err;
    assign rx_overrun_error = r_ovr_err;

    // ------------------------------------------------------------------
    // Receive FIFO. r_tdata mirrors the head entry so the output only
    // moves on a pop or on a push into an empty buffer.
    // ------------------------------------------------------------------
    assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tdata  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_push && (r_count == '0)) begin
                r_tdata <= r_shift;
            end else if (w_pop) begin
                if (r_count > CW'(1)) begin
                    r_tdata <= r_mem[w_rd_ptr_inc];
                end else if (w_push) begin
                    // Last word leaves while a new one arrives.
                    r_tdata <= r_shift;
                end
            end
        end
    end

    assign m_axis.m_axis_tdata  = r_tdata;
    assign m_axis.m_axis_tvalid = (r_count != '0);
    assign fifo_count           = r_count;

endmodule

// File: tb/tb_uart_rx_buf.sv
module tb_uart_rx_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    // Frame outcome codes as seen at the end of a frame.
    localparam logic [3:0] OUT_NONE = 4'h0;
    localparam logic [3:0] OUT_PUSH = 4'h1;
    localparam logic [3:0] OUT_FERR = 4'h2;
    localparam logic [3:0] OUT_PERR = 4'h4;
    localparam logic [3:0] OUT_OVR  = 4'h8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rx = 1'b1;
    logic [15:0]   prescale = 16'd16;
    logic          tready = 1'b0;
    logic          rx_busy;
    logic          rx_frame_error;
    logic          rx_parity_error;
    logic          rx_overrun_error;
    logic [2:0]    fifo_count;
    logic [DW-1:0] tdata;
    logic          tvalid;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_buf_if #(.DATA_WIDTH(DW)) axis_if ();
    assign axis_if.m_axis_tready = tready;
    assign tdata  = axis_if.m_axis_tdata;
    assign tvalid = axis_if.m_axis_tvalid;

    uart_rx_buf #(
        .DATA_WIDTH(DW),
        .PARITY    (1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .RX_i            (rx),
        .prescale        (prescale),
        .m_axis          (axis_if),
        .rx_busy         (rx_busy),
        .rx_frame_error  (rx_frame_error),
        .rx_parity_error (rx_parity_error),
        .rx_overrun_error(rx_overrun_error),
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: words expected to come out, in order.
    // ------------------------------------------------------------------
    logic [DW-1:0] exp_q[$];

    // Outcome of a frame from the line-level rules alone. The buffer
    // occupancy at resolution is the model queue size when the consumer is
    // stalled, and zero when it is draining.
    function automatic logic [3:0] predict(input logic [7:0] d, input logic p, input logic s);
        if (!s)                                  return OUT_FERR;
        if ((^d ^ p) != 1'b0)                    return OUT_PERR;
        if (!tready && exp_q.size() == DEPTH)    return OUT_OVR;
        return OUT_PUSH;
    endfunction

    // ------------------------------------------------------------------
    // Monitor (negedge): end-of-frame outcomes, stray pulses, pops.
    // ------------------------------------------------------------------
    int         ends_seen   = 0;
    int         stray       = 0;
    int         busy_cycles = 0;
    logic [3:0] last_outcome = 4'h0;
    logic       prev_busy = 1'b0;
    int         prev_count = 0;
    int         pop_prev = 0;

    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_busy  = 1'b0;
            prev_count = 0;
            pop_prev   = 0;
        end else begin
            if (prev_busy && !rx_busy) begin
                last_outcome = {rx_overrun_error, rx_parity_error, rx_frame_error,
                                (int'(fifo_count) + pop_prev - prev_count) == 1};
                ends_seen++;
            end else if (rx_frame_error || rx_parity_error || rx_overrun_error) begin
                stray++;
            end
            if (rx_busy) busy_cycles++;
            if (tvalid && tready) begin
                check_val("pop_model_nonempty", 32'(tvalid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check_val("pop_data", 32'(tdata), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                pop_prev = 1;
            end else begin
                pop_prev = 0;
            end
            prev_busy  = rx_busy;
            prev_count = int'(fifo_count);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        check_val({tag, "_tdata"},  32'(tdata), 32'd0);
        check_val({tag, "_busy"},   32'(rx_busy), 32'd0);
        check_val({tag, "_errs"},   32'({rx_frame_error, rx_parity_error, rx_overrun_error}), 32'd0);
        check_val({tag, "_count"},  32'(fifo_count), 32'd0);
    endtask

    // Drives one frame; if rst_bit selects a data bit, reset is asserted in
    // the middle of that bit and left asserted.
    task automatic send_bits(input logic [7:0] d, input logic p, input logic s,
                             input int ps, input int rst_bit);
        rx = 1'b0;
        repeat (ps) tick();
        for (int j = 0; j < DW; j++) begin
            rx = d[j];
            if (j == rst_bit) begin
                repeat (ps / 2) tick();
                rst_ni = 1'b0;
                #1;
                check_reset_outputs("midframe_rst");
                repeat (ps - ps / 2) tick();
            end else begin
                repeat (ps) tick();
            end
        end
        rx = p;
        repeat (ps) tick();
        rx = s;
        repeat (ps) tick();
        rx = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] d, input logic p, input logic s,
                             input int ps_drive, input logic [15:0] ps_port);
        logic [3:0] expo;
        int         e0;
        expo = predict(d, p, s);
        if (expo == OUT_PUSH) exp_q.push_back(d);
        prescale = ps_port;
        e0 = ends_seen;
        send_bits(d, p, s, ps_drive, -1);
        repeat (ps_drive * 2 + 8) tick();
        check_val("frame_end_count", 32'(ends_seen - e0), 32'd1);
        check_val("frame_outcome", 32'(last_outcome), 32'(expo));
        check_val("frame_fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        $display("frame data=0x%02h par=%0b stop=%0b ps=%0d tready=%0b outcome=0x%0h expect=0x%0h count=%0d",
                 d, p, s, ps_drive, tready, last_outcome, expo, fifo_count);
    endtask

    task automatic drain();
        tready = 1'b1;
        repeat (DEPTH * 3) tick();
        check_val("drain_count", 32'(fifo_count), 32'(exp_q.size()));
        check_val("drain_tvalid", 32'(tvalid), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         e0;
        int         b0;
        logic [7:0] d;
        logic       p;
        logic       s;
        int         ps;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        repeat (6) tick();

        // Good frame 0xA5 with even parity bit 0
        tready = 1'b0;
        run_frame(8'hA5, 1'b0, 1'b1, 16, 16'd16);
        check_val("a5_tvalid", 32'(tvalid), 32'd1);
        check_val("a5_tdata", 32'(tdata), 32'hA5);
        tready = 1'b1;
        repeat (4) tick();
        check_val("a5_popped_count", 32'(fifo_count), 32'd0);

        // Parity error and framing error
        run_frame(8'hA5, 1'b1, 1'b1, 16, 16'd16);
        check_val("perr_tvalid", 32'(tvalid), 32'd0);
        run_frame(8'h3C, 1'b0, 1'b0, 16, 16'd16);

        // Fill the buffer with the consumer stalled; fifth word overruns
        tready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            run_frame(d, ^d, 1'b1, 16, 16'd16);
        end
        check_val("full_count", 32'(fifo_count), 32'(DEPTH));
        drain();

        // Short low glitch: busy briefly, no word, no error
        e0 = ends_seen;
        b0 = busy_cycles;
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (40) tick();
        check_val("glitch_end_count", 32'(ends_seen - e0), 32'd1);
        check_val("glitch_outcome", 32'(last_outcome), 32'(OUT_NONE));
        check_val("glitch_busy_seen", 32'(busy_cycles > b0), 32'd1);
        check_val("glitch_count", 32'(fifo_count), 32'd0);
        $display("glitch busy_cycles=%0d outcome=0x%0h", busy_cycles - b0, last_outcome);

        // Reset in the middle of a frame with a word still buffered
        tready = 1'b0;
        run_frame(8'h77, ^8'h77, 1'b1, 16, 16'd16);
        send_bits(8'h55, ^8'h55, 1'b1, 16, 3);
        exp_q.delete();
        repeat (20) tick();
        check_reset_outputs("held_rst");
        rst_ni = 1'b1;
        repeat (10) tick();
        run_frame(8'h99, ^8'h99, 1'b1, 16, 16'd16);
        check_val("after_rst_tdata", 32'(tdata), 32'h99);
        drain();

        // prescale below the floor behaves as 4
        run_frame(8'h5A, ^8'h5A, 1'b1, 4, 16'd2);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            tready = ($urandom_range(2, 0) == 0);
            repeat (8) tick();
            d  = 8'($urandom_range(255, 0));
            p  = ^d ^ ($urandom_range(9, 0) == 0);
            s  = ($urandom_range(9, 0) != 0);
            ps = int'($urandom_range(20, 4));
            run_frame(d, p, s, ps, 16'(ps));
        end
        drain();

        check_val("stray_pulses", 32'(stray), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame (5..9).
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter FIFO_DEPTH, default 16, receive buffer entries (power of 2, >=2).
REQ-004 Port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 Port rst_ni  in  1  asynchronous active-low reset.
REQ-006 Port RX_i  in  1  serial line, idle high, asynchronous to clk_i.
REQ-007 Port prescale  in  16  clock cycles per bit period.
REQ-008 Port m_axis_tdata  out  DATA_WIDTH  head-of-buffer word.
REQ-009 Port m_axis_tvalid  out  1  buffer non-empty.
REQ-010 Port m_axis_tready  in  1  consumer accepts word.
REQ-011 Port rx_busy  out  1  frame in progress (any state other than IDLE).
REQ-012 Port rx_frame_error  out  1  one-cycle pulse: stop bit sampled low.
REQ-013 Port rx_parity_error  out  1  one-cycle pulse: parity mismatch.
REQ-014 Port rx_overrun_error  out  1  one-cycle pulse: valid frame dropped, buffer full.
REQ-015 Port fifo_count  out  $clog2(FIFO_DEPTH+1)  words currently buffered.

Function
REQ-016 RX_i SHALL pass through a 2-flop synchronizer reset to 1; all decoding uses the synchronized value.
REQ-017 prescale SHALL be latched at start detection; values below 4 are treated as 4.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE->START on synchronized falling edge (previous 1, current 0); a line held low out of reset is not a start.
REQ-020 START: sample after prescale>>1 cycles; low -> DATA, high -> IDLE (glitch rejected, no error pulse).
REQ-021 DATA: DATA_WIDTH samples, each prescale cycles after the previous, LSB first.
REQ-022 PARITY (only when PARITY!=0): one sample prescale cycles after last data bit; even mode requires XOR of data and parity bit = 0, odd mode = 1.
REQ-023 STOP: one sample prescale cycles after previous sample; frame resolved in that cycle; FSM -> IDLE next cycle.
REQ-024 Resolution priority: stop low -> rx_frame_error, word dropped; else parity mismatch -> rx_parity_error, word dropped; else buffer full -> rx_overrun_error, word dropped; else word pushed.
REQ-025 Error pulses SHALL be asserted exactly one cycle, the cycle after stop sample.
REQ-026 Pushed word visible (m_axis_tvalid=1 if previously empty) one cycle after stop sample.
REQ-027 Pop on m_axis_tvalid && m_axis_tready; m_axis_tdata changes only on pop or on push into empty buffer.
REQ-028 Push and pop in the same cycle SHALL both occur; full with simultaneous pop is not overrun.
REQ-029 Buffer pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH or underflows.
REQ-030 Words leave in arrival order; no word duplicated or lost except per REQ-024.
REQ-031 Incoming frames SHALL be received regardless of m_axis_tready.

Reset
REQ-032 rst_ni low asynchronously: FSM IDLE, counters 0, buffer empty, synchronizer 1.
REQ-033 Outputs during/after reset: m_axis_tvalid 0, m_axis_tdata 0, rx_busy 0, all error pulses 0, fifo_count 0.
REQ-034 Reset mid-frame aborts the frame with no push and no error pulse; reception resumes on next falling edge after release.

Verification (DATA_WIDTH=8, PARITY=1, FIFO_DEPTH=4, prescale=16)
REQ-035 Frame 0xA5, parity bit 0, stop 1 -> m_axis_tdata=0xA5, tvalid=1 one cycle after stop sample, fifo_count=1; tready=1 -> count 0.
REQ-036 Frame 0xA5 with parity bit 1 -> rx_parity_error pulse 1 cycle, tvalid stays 0, count 0.
REQ-037 Frame 0x3C with stop bit 0 -> rx_frame_error pulse, no push.
REQ-038 tready=0, frames 0x01..0x05 -> count 4, overrun pulse on 5th; then tready=1 drains 0x01,0x02,0x03,0x04 in order.
REQ-039 RX_i low for 4 cycles then high -> rx_busy pulses, returns to IDLE, no push, no error.
REQ-040 rst_ni low during data bit 3 of 0x55 -> all outputs 0; next clean frame 0x99 received correctly.
